program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Architectural program-counter register for the single-cycle RISC datapath.
- Captures the next-PC value (`pc_in`, computed upstream by the next-PC mux) on every rising clock edge.
- Presents the current fetch address (`pc_out`) to instruction memory and the PC+4 adder.
- Adds sequential-address, alignment-status and validity outputs for fetch and debug logic.

Parameters:
- `N`, default 32: address width in bits; legal range is N ≥ 3.
- `RESET_VECTOR`, default 32'h0000_0000 (N bits): value forced onto `pc_out` while reset is asserted.
- `INSTR_BYTES`, default 4: fetch step added to form `pc_plus4`; it must be a power of two.

Ports:
- `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset (0 = in reset).
- `pc_in`, input, N bits: next-PC value to capture.
- `pc_out`, output, N bits: registered current PC.
- `pc_plus4`, output, N bits: `pc_out + INSTR_BYTES`, combinational.
- `misaligned`, output, 1 bit: combinational flag; high when the low log2(`INSTR_BYTES`) bits of `pc_out` are nonzero.
- `pc_valid`, output, 1 bit: registered flag; low in reset, high from the first rising edge after reset release.

Behaviour:
- Reset assertion (`reset` = 0):
  - `pc_out` ← `RESET_VECTOR` and `pc_valid` ← 0 immediately, with no clock edge required.
  - Both hold those values for as long as `reset` = 0; `pc_in` is ignored.
- Reset mid-operation: asserting `reset` at any time overrides the clock and takes effect asynchronously, exactly as above.
- Reset release (`reset` 0→1):
  - No output changes at release itself.
  - The first rising `clk` edge after release loads `pc_in` and sets `pc_valid` = 1.
- Normal operation (`reset` = 1):
  - Every rising `clk` edge: `pc_out` ← `pc_in`, `pc_valid` ← 1.
  - Latency is exactly one cycle, with no enable and no stall; a constant `pc_in` therefore holds `pc_out`.
- `pc_in` is stored verbatim. There is no masking of low bits and no truncation; bit widths match.
- `pc_plus4`:
  - Modulo-2^N addition with no carry-out.
  - At `pc_out` = all-ones − 3, it wraps to 0.
  - In reset it reflects `RESET_VECTOR + INSTR_BYTES`.
- `misaligned`:
  - Purely combinational from `pc_out`.
  - The block takes no corrective action; trap handling is upstream.
- Before the first reset or edge in simulation, outputs are X. Benches must apply reset first.
- No internal state beyond the `pc_out` and `pc_valid` flops.
- Assertions, embedded and disabled in synthesis:
  - `pc_out` == `RESET_VECTOR` whenever `reset` = 0.
  - `pc_valid` implies `pc_out` == `$past(pc_in)` at each edge.
  - Elaboration-time check on the parameter legality rules.

Decomposition:
- Shared package `cpu_pkg`: `addr_t` (logic [N-1:0]), `RESET_VECTOR` and `INSTR_BYTES` constants, reused by fetch and the branch unit.
- One natural sub-module: `pc_incrementer`, a parameterised combinational adder producing `pc_plus4`.
- Flops and assertions stay in `program_counter`.

Test Plan:
- Reset, then release:
  - `reset`=0 with `pc_in`=0x0040_0000 → `pc_out`=0x0000_0000 immediately, `pc_valid`=0, `pc_plus4`=0x0000_0004.
  - Set `reset`=1 → the next rising edge gives `pc_out`=0x0040_0000, `pc_valid`=1.
- Update: `pc_in`=0x0040_0004 before an edge → `pc_out`=0x0040_0004 after that edge; `pc_plus4`=0x0040_0008; `misaligned`=0.
- Hold: `pc_in` held at 0x0040_0004 for 3 edges → `pc_out` stays 0x0040_0004.
- Asynchronous mid-cycle reset: drive `reset`=0 at mid-period (no edge) → `pc_out`=`RESET_VECTOR` within the same timestep, `pc_valid`=0; it stays there across subsequent edges.
- Wrap: `pc_in`=0xFFFF_FFFC → after the edge, `pc_plus4`=0x0000_0000.
- Alignment: `pc_in`=0x0040_0002 → after the edge, `misaligned`=1 and `pc_out`=0x0040_0002 (unmasked).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and architectural constants used by fetch, the branch unit and the PC.
package cpu_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-address adder: pc + STEP, wrapping modulo 2^N with the carry-out dropped.
module pc_incrementer #(
    parameter int N    = cpu_pkg::ADDR_W,
    parameter int STEP = cpu_pkg::INSTR_BYTES
) (
    input  logic [N-1:0] pc,
    output logic [N-1:0] pc_next
);

    assign pc_next = pc + N'(STEP);

endmodule

// File: rtl/program_counter.sv
// Architectural PC register: captures pc_in every edge, exposes the fetch address,
// the sequential address, an alignment flag and a post-reset validity flag.
module program_counter #(
    parameter int             N            = cpu_pkg::ADDR_W,
    parameter logic [N-1:0]   RESET_VECTOR = N'(cpu_pkg::RESET_VECTOR),
    parameter int             INSTR_BYTES  = cpu_pkg::INSTR_BYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_in,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] pc_plus4,
    output logic         misaligned,
    output logic         pc_valid
);

    // Low bits that must be zero for an instruction-aligned fetch address.
    localparam logic [N-1:0] ALIGN_MASK = N'(INSTR_BYTES - 1);

    // Active-low reset overrides the clock; pc_in is stored verbatim otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out   <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            pc_out   <= pc_in;
            pc_valid <= 1'b1;
        end
    end

    pc_incrementer #(
        .N    (N),
        .STEP (INSTR_BYTES)
    ) u_pc_incrementer (
        .pc      (pc_out),
        .pc_next (pc_plus4)
    );

    // Status only: trapping on a misaligned fetch is handled upstream.
    assign misaligned = (pc_out & ALIGN_MASK) != '0;

`ifndef SYNTHESIS
    generate
        if (N < 3 || INSTR_BYTES < 1 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_params
            $error("program_counter: N must be >= 3 and INSTR_BYTES a power of two");
        end
    endgenerate

    a_reset_vector: assert property (@(posedge clk) !reset |-> pc_out == RESET_VECTOR);

    a_capture: assert property (@(posedge clk) disable iff (!reset)
        pc_valid |-> pc_out == $past(pc_in));
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic
// compared against a queue-based model of captured addresses.
module tb_program_counter;
    import cpu_pkg::*;

    logic  clk;
    logic  reset;
    addr_t pc_in;
    addr_t pc_out;
    addr_t pc_plus4;
    logic  misaligned;
    logic  pc_valid;

    int checks = 0;
    int errors = 0;

    // Every address the PC has captured since the last reset; the newest is the current PC.
    addr_t exp_q[$];
    bit    in_reset;

    program_counter dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned),
        .pc_valid   (pc_valid)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic addr_t exp_pc();
        if (in_reset || exp_q.size() == 0) return RESET_VECTOR;
        return exp_q[$];
    endfunction

    function automatic logic exp_valid();
        return !in_reset && exp_q.size() > 0;
    endfunction

    function automatic addr_t exp_plus4();
        logic [ADDR_W:0] sum;
        sum = {1'b0, exp_pc()} + (ADDR_W + 1)'(INSTR_BYTES);
        return sum[ADDR_W-1:0];
    endfunction

    function automatic logic exp_misaligned();
        return (exp_pc() % INSTR_BYTES) != 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Present v, take one rising edge, return at the following falling edge.
    task automatic drive_edge(input addr_t v);
        pc_in = v;
        @(posedge clk);
        if (!in_reset) exp_q.push_back(v);
        @(negedge clk);
    endtask

    task automatic assert_reset_mid();
        reset    = 1'b0;
        in_reset = 1'b1;
        exp_q.delete();
        #1;
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        in_reset = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        pc_in    = 32'h0040_0000;
        reset    = 1'b0;
        in_reset = 1'b1;
        #1;
        checks++; if (pc_out !== exp_pc()) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, exp_pc()); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pc_valid); end
        checks++; if (pc_plus4 !== 32'h0000_0004) begin errors++; $display("FAIL reset_plus4 got %h want 00000004", pc_plus4); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (pc_out !== RESET_VECTOR) begin errors++; $display("FAIL reset_hold_pc got %h want %h", pc_out, RESET_VECTOR); end
    endtask

    task automatic test_release();
        release_reset();
        checks++; if (pc_out !== RESET_VECTOR || pc_valid !== 1'b0) begin
            errors++; $display("FAIL release_no_change got pc=%h valid=%b want pc=%h valid=0", pc_out, pc_valid, RESET_VECTOR);
        end
        drive_edge(32'h0040_0000);
        checks++; if (pc_out !== 32'h0040_0000) begin errors++; $display("FAIL release_pc got %h want 00400000", pc_out); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %b want 1", pc_valid); end
    endtask

    task automatic test_update();
        drive_edge(32'h0040_0004);
        checks++; if (pc_out !== 32'h0040_0004) begin errors++; $display("FAIL update_pc got %h want 00400004", pc_out); end
        checks++; if (pc_plus4 !== 32'h0040_0008) begin errors++; $display("FAIL update_plus4 got %h want 00400008", pc_plus4); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL update_misaligned got %b want 0", misaligned); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            drive_edge(32'h0040_0004);
            checks++; if (pc_out !== 32'h0040_0004) begin errors++; $display("FAIL hold_pc[%0d] got %h want 00400004", i, pc_out); end
        end
    endtask

    task automatic test_async_reset();
        drive_edge(32'h1234_5678);
        // Reset lands mid-period, well away from any rising edge.
        #2;
        assert_reset_mid();
        checks++; if (pc_out !== RESET_VECTOR) begin errors++; $display("FAIL async_pc got %h want %h", pc_out, RESET_VECTOR); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", pc_valid); end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            drive_edge($urandom);
            checks++; if (pc_out !== RESET_VECTOR || pc_valid !== 1'b0) begin
                errors++; $display("FAIL async_hold[%0d] got pc=%h valid=%b want pc=%h valid=0", i, pc_out, pc_valid, RESET_VECTOR);
            end
        end
        release_reset();
        drive_edge(32'h0040_0010);
        checks++; if (pc_out !== 32'h0040_0010 || pc_valid !== 1'b1) begin
            errors++; $display("FAIL async_recover got pc=%h valid=%b want pc=00400010 valid=1", pc_out, pc_valid);
        end
    endtask

    task automatic test_wrap();
        drive_edge(32'hFFFF_FFFC);
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", pc_out); end
        checks++; if (pc_plus4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_plus4 got %h want 00000000", pc_plus4); end
    endtask

    task automatic test_alignment();
        drive_edge(32'h0040_0002);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL align_misaligned got %b want 1", misaligned); end
        checks++; if (pc_out !== 32'h0040_0002) begin errors++; $display("FAIL align_pc got %h want 00400002", pc_out); end
        drive_edge(32'h0040_0001);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL align_bit0 got %b want 1", misaligned); end
        drive_edge(32'h0040_0008);
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL align_clear got %b want 0", misaligned); end
    endtask

    task automatic test_random();
        addr_t v;
        for (int i = 0; i < 200; i++) begin
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = 32'hFFFF_FFF0 | addr_t'($urandom_range(0, 15));
            drive_edge(v);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                assert_reset_mid();
                @(negedge clk);
                drive_edge($urandom);
                release_reset();
            end
            checks++; if (pc_out !== exp_pc()) begin errors++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc_out, exp_pc()); end
            checks++; if (pc_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid[%0d] got %b want %b", i, pc_valid, exp_valid()); end
            checks++; if (pc_plus4 !== exp_plus4()) begin errors++; $display("FAIL rand_plus4[%0d] got %h want %h", i, pc_plus4, exp_plus4()); end
            checks++; if (misaligned !== exp_misaligned()) begin errors++; $display("FAIL rand_misaligned[%0d] got %b want %b", i, misaligned, exp_misaligned()); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_release();
        test_update();
        test_hold();
        test_async_reset();
        test_wrap();
        test_alignment();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
